color_tone_filter: RTL and testbench
====================================

Name: color_tone_filter

Overview:
Parametrised, mode-selectable RGB565 tone filter for the camera-to-framebuffer write stream. It sits inline between the OV7670 capture/pixel-write path and the frame buffer, and passes the write enable, address and data stream through a fixed 2-cycle pipeline. It generalises the single fixed cool tint to runtime-selectable modes: bypass, cool, warm, grayscale and invert, with programmable tint strength. Mode changes take effect only at frame boundaries, so a single frame is never rendered with mixed settings. It also reports end-of-frame and keeps a frame count.

Parameters:
IMG_WIDTH, 320, pixels per line
IMG_HEIGHT, 240, lines per frame
AW, $clog2(IMG_WIDTH*IMG_HEIGHT), address width (derived; not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_mode  in  3  requested mode: 0 bypass, 1 cool, 2 warm, 3 grayscale, 4 invert, 5-7 reserved (treated as bypass)
cfg_strength  in  4  requested tint strength S (0-15), used by cool and warm only
we_in  in  1  input pixel write strobe
wAddr_in  in  AW  input pixel address
wData_in  in  16  input pixel, RGB565 {r[4:0],g[5:0],b[4:0]}
we_out  out  1  output write strobe (we_in delayed 2 cycles)
wAddr_out  out  AW  output address
wData_out  out  16  filtered RGB565 pixel
active_mode  out  3  mode currently applied
frame_done  out  1  single-cycle pulse with the last pixel of a frame
frame_count  out  16  count of completed frames; wraps at 0xFFFF to 0

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values:
  - we_out=0, wAddr_out=0, wData_out=0.
  - frame_done=0, frame_count=0.
  - active_mode=0 (bypass), active strength=0.
  - All internal pipeline valid bits cleared.
- Reset asserted mid-frame:
  - Discards in-flight pixels; they never appear on we_out.
  - Returns the block to bypass.
- Settings latch (frame start):
  - When we_in=1 and wAddr_in==0, active mode/strength load from cfg_mode/cfg_strength.
  - That address-0 pixel is itself processed with the new settings.
  - At all other times cfg_* are ignored.
  - Reserved modes 5-7 are latched as given, and active_mode reports the raw value; they behave as bypass.
- Pipeline (latency exactly 2 cycles, one pixel per cycle, no backpressure):
  - Stage 1 registers the valid bit, address, unpacked channels and the latched settings, and computes luma products.
  - Stage 2 computes the final channels and drives the outputs.
  - The valid bit shifts every cycle.
  - Address and data stage registers load only when their stage valid is 1; otherwise they hold.
  - When we_out=0, wAddr_out/wData_out therefore hold the last valid pixel.
- Mode arithmetic, unsigned, with saturation via widened intermediates (no wrap):
  - bypass: out = in.
  - cool: b = min(b+S, 31); r = max(r-S, 0); g unchanged.
  - warm: r = min(r+S, 31); b = max(b-S, 0); g unchanged.
  - grayscale:
    - Expand to 6 bits: r6={r,r[4]}, b6={b,b[4]}.
    - Y = (77*r6 + 150*g + 29*b6) >> 8, using a 14-bit sum; Y is 0-63.
    - Output {Y[5:1], Y, Y[5:1]}.
  - invert: out = ~in (bitwise, all 16 bits).
- frame_done:
  - Asserted for 1 cycle exactly when we_out=1 and wAddr_out == IMG_WIDTH*IMG_HEIGHT-1.
  - frame_count increments on the same edge that asserts frame_done.
- Back-to-back frames: an address-0 pixel may immediately follow the last pixel. The new settings apply to it while the preceding pixel completes with the old settings.
- Gaps (we_in=0) of any length are allowed anywhere. Addresses are not checked for ordering.

Test Plan:
1. Reset, then cfg_mode=1, S=2; drive we_in=1 with wAddr_in=0, wData_in=0x8410 -> two cycles later we_out=1, wAddr_out=0, wData_out=0x7412, active_mode=1.
2. Mode 2, S=4; frame-start pixel 0xF801 -> 0xF800 (r saturates at 31, b clamps to 0). Then mode 1, S=15, pixel 0x001F at address 0 -> 0x001F.
3. Mode 3 at frame start; feed 0xF800, 0xFFFF, 0x0000 on consecutive cycles -> outputs 0x4A49, 0xFFFF, 0x0000 on 3 consecutive cycles.
4. Frame running in mode 4; change cfg_mode to 0 at address 100 -> 0x1234 at address 101 outputs 0xEDCB. The next address-0 pixel 0x1234 outputs 0x1234, and active_mode switches to 0.
5. Stream addresses 76798, 76799, 0 with default parameters -> frame_done pulses only with wAddr_out=76799, and frame_count goes 0->1.
6. Assert reset for 1 cycle while 2 pixels are in flight -> no we_out for those pixels, all outputs 0, active_mode=0. Insert 3 idle cycles mid-stream -> we_out low for 3 cycles and wData_out holds its value.

Source files
------------

// File: rtl/color_tone_filter.sv
// Inline RGB565 tone filter for the camera write stream: 2-cycle pipeline with
// frame-boundary mode/strength latching, end-of-frame pulse and frame counter.
module color_tone_filter #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  localparam int AW = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    cfg_mode,
  input  logic [3:0]    cfg_strength,
  input  logic          we_in,
  input  logic [AW-1:0] wAddr_in,
  input  logic [15:0]   wData_in,
  output logic          we_out,
  output logic [AW-1:0] wAddr_out,
  output logic [15:0]   wData_out,
  output logic [2:0]    active_mode,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_WIDTH*IMG_HEIGHT-1);

  logic [2:0] mode_reg;
  logic [3:0] strength_reg;
  logic       frame_start;
  logic [2:0] mode_sel;
  logic [3:0] strength_sel;

  // The address-0 pixel must already see the new settings, so bypass the latch.
  assign frame_start  = we_in && (wAddr_in == '0);
  assign mode_sel     = frame_start ? cfg_mode : mode_reg;
  assign strength_sel = frame_start ? cfg_strength : strength_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg     <= 3'd0;
      strength_reg <= 4'd0;
    end else if (frame_start) begin
      mode_reg     <= cfg_mode;
      strength_reg <= cfg_strength;
    end
  end

  assign active_mode = mode_reg;

  // Stage 1: capture pixel, settings and the three luma products.
  logic          s1_valid_reg;
  logic [AW-1:0] s1_addr_reg;
  logic [15:0]   s1_pix_reg;
  logic [2:0]    s1_mode_reg;
  logic [3:0]    s1_strength_reg;
  logic [12:0]   s1_yr_reg;
  logic [13:0]   s1_yg_reg;
  logic [10:0]   s1_yb_reg;

  logic [5:0] r6_in, b6_in;
  assign r6_in = {wData_in[15:11], wData_in[15]};
  assign b6_in = {wData_in[4:0], wData_in[4]};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg    <= 1'b0;
      s1_addr_reg     <= '0;
      s1_pix_reg      <= 16'd0;
      s1_mode_reg     <= 3'd0;
      s1_strength_reg <= 4'd0;
      s1_yr_reg       <= 13'd0;
      s1_yg_reg       <= 14'd0;
      s1_yb_reg       <= 11'd0;
    end else begin
      s1_valid_reg <= we_in;
      if (we_in) begin
        s1_addr_reg     <= wAddr_in;
        s1_pix_reg      <= wData_in;
        s1_mode_reg     <= mode_sel;
        s1_strength_reg <= strength_sel;
        s1_yr_reg       <= {7'd0, r6_in} * 13'd77;
        s1_yg_reg       <= {8'd0, wData_in[10:5]} * 14'd150;
        s1_yb_reg       <= {5'd0, b6_in} * 11'd29;
      end
    end
  end

  // Stage 2: saturating tint on red (gi=0) and blue (gi=1), luma, mode mux.
  logic [4:0] ch_in  [2];
  logic [4:0] ch_add [2];
  logic [4:0] ch_sub [2];

  assign ch_in[0] = s1_pix_reg[15:11];
  assign ch_in[1] = s1_pix_reg[4:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_tint
      logic [5:0] sum_w;
      assign sum_w      = {1'b0, ch_in[gi]} + {2'b00, s1_strength_reg};
      assign ch_add[gi] = sum_w[5] ? 5'd31 : sum_w[4:0];
      assign ch_sub[gi] = ({1'b0, ch_in[gi]} >= {2'b00, s1_strength_reg})
                          ? (ch_in[gi] - {1'b0, s1_strength_reg}) : 5'd0;
    end
  endgenerate

  logic [13:0] y_sum;
  logic [5:0]  y;
  logic [15:0] pix_next;

  assign y_sum = {1'b0, s1_yr_reg} + s1_yg_reg + {3'd0, s1_yb_reg};
  assign y     = y_sum[13:8];

  always_comb begin
    pix_next = s1_pix_reg;
    case (s1_mode_reg)
      3'd1:    pix_next = {ch_sub[0], s1_pix_reg[10:5], ch_add[1]};
      3'd2:    pix_next = {ch_add[0], s1_pix_reg[10:5], ch_sub[1]};
      3'd3:    pix_next = {y[5:1], y, y[5:1]};
      3'd4:    pix_next = ~s1_pix_reg;
      default: pix_next = s1_pix_reg;
    endcase
  end

  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [15:0]   data_reg;
  logic          frame_done_reg;
  logic [15:0]   frame_count_reg;
  logic          last_pix;

  assign last_pix = s1_valid_reg && (s1_addr_reg == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= 16'd0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= 16'd0;
    end else begin
      we_reg         <= s1_valid_reg;
      frame_done_reg <= last_pix;
      if (last_pix) frame_count_reg <= frame_count_reg + 16'd1;
      if (s1_valid_reg) begin
        addr_reg <= s1_addr_reg;
        data_reg <= pix_next;
      end
    end
  end

  assign we_out      = we_reg;
  assign wAddr_out   = addr_reg;
  assign wData_out   = data_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_color_tone_filter.sv
// Scoreboard bench for color_tone_filter: directed pixels push expected results,
// a negedge monitor pops and compares whenever we_out is high.
module tb_color_tone_filter;

  localparam int AW   = 17;
  localparam int LAST = 76799;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    cfg_mode;
  logic [3:0]    cfg_strength;
  logic          we_in;
  logic [AW-1:0] wAddr_in;
  logic [15:0]   wData_in;
  logic          we_out;
  logic [AW-1:0] wAddr_out;
  logic [15:0]   wData_out;
  logic [2:0]    active_mode;
  logic          frame_done;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  color_tone_filter dut (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_strength(cfg_strength),
    .we_in(we_in), .wAddr_in(wAddr_in), .wData_in(wData_in),
    .we_out(we_out), .wAddr_out(wAddr_out), .wData_out(wData_out),
    .active_mode(active_mode), .frame_done(frame_done), .frame_count(frame_count)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic          fd;
  } exp_t;

  exp_t q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one pixel for one cycle and record its expected output.
  task automatic pix(input int a, input logic [15:0] d, input logic [15:0] e);
    we_in    = 1'b1;
    wAddr_in = AW'(a);
    wData_in = d;
    q.push_back('{AW'(a), e, (a == LAST)});
    @(posedge clk); #1;
    we_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (we_out) begin
        if (q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_pixel: got addr %0d data 0x%0h, expected none", wAddr_out, wData_out);
        end else begin
          e = q.pop_front();
          check("out_addr", 32'(wAddr_out), 32'(e.a));
          check("out_data", 32'(wData_out), 32'(e.d));
          check("frame_done", 32'(frame_done), 32'(e.fd));
        end
      end else if (frame_done) begin
        check("frame_done_idle", 32'(frame_done), 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; cfg_mode = 3'd0; cfg_strength = 4'd0;
    we_in = 1'b0; wAddr_in = '0; wData_in = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_we_out", 32'(we_out), 32'd0);
    check("rst_addr", 32'(wAddr_out), 32'd0);
    check("rst_data", 32'(wData_out), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_active_mode", 32'(active_mode), 32'd0);

    // Cool, S=2
    cfg_mode = 3'd1; cfg_strength = 4'd2;
    pix(0, 16'h8410, 16'h7412);
    idle(2);
    check("cool_active_mode", 32'(active_mode), 32'd1);

    // Warm saturation, then cool saturation
    cfg_mode = 3'd2; cfg_strength = 4'd4;
    pix(0, 16'hF801, 16'hF800);
    cfg_mode = 3'd1; cfg_strength = 4'd15;
    pix(0, 16'h001F, 16'h001F);
    idle(2);

    // Grayscale, back-to-back
    cfg_mode = 3'd3;
    pix(0, 16'hF800, 16'h4A49);
    pix(1, 16'hFFFF, 16'hFFFF);
    pix(2, 16'h0000, 16'h0000);
    idle(2);
    check("gray_active_mode", 32'(active_mode), 32'd3);

    // Invert; mid-frame cfg change is ignored until next address 0
    cfg_mode = 3'd4;
    pix(0, 16'h1234, 16'hEDCB);
    cfg_mode = 3'd0;
    pix(100, 16'h0000, 16'hFFFF);
    pix(101, 16'h1234, 16'hEDCB);
    idle(2);
    check("midframe_active_mode", 32'(active_mode), 32'd4);
    pix(0, 16'h1234, 16'h1234);
    idle(2);
    check("newframe_active_mode", 32'(active_mode), 32'd0);

    // Frame boundary
    pix(76798, 16'h0AAA, 16'h0AAA);
    pix(76799, 16'h0555, 16'h0555);
    pix(0, 16'h1111, 16'h1111);
    idle(2);
    check("frame_count_1", 32'(frame_count), 32'd1);

    // Reserved mode behaves as bypass, reported raw
    cfg_mode = 3'd6; cfg_strength = 4'd9;
    pix(0, 16'hA5C3, 16'hA5C3);
    idle(2);
    check("reserved_active_mode", 32'(active_mode), 32'd6);

    // Reset with two pixels in flight
    cfg_mode = 3'd4;
    pix(0, 16'h1234, 16'hEDCB);
    idle(2);
    we_in = 1'b1; wAddr_in = AW'(10); wData_in = 16'hAAAA;
    @(posedge clk); #1;
    wAddr_in = AW'(11); wData_in = 16'h5555; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; we_in = 1'b0;
    check("mid_rst_we_out", 32'(we_out), 32'd0);
    check("mid_rst_addr", 32'(wAddr_out), 32'd0);
    check("mid_rst_data", 32'(wData_out), 32'd0);
    check("mid_rst_frame_count", 32'(frame_count), 32'd0);
    check("mid_rst_active_mode", 32'(active_mode), 32'd0);
    idle(3);

    // Three idle input cycles: outputs hold the last valid pixel
    cfg_mode = 3'd4;
    pix(0, 16'h1234, 16'hEDCB);
    fork
      begin
        idle(3);
        pix(1, 16'h0F0F, 16'hF0F0);
      end
      begin
        @(posedge clk); #1;
        check("gap_first_valid", 32'(we_out), 32'd1);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          check("gap_we_low", 32'(we_out), 32'd0);
          check("gap_data_hold", 32'(wData_out), 32'h0000EDCB);
        end
        @(posedge clk); #1;
        check("gap_resume_valid", 32'(we_out), 32'd1);
      end
    join
    idle(4);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
